// File: rtl/rvv_backend_dispatch_credit_ctrl.sv
// rvv_backend_dispatch_credit_ctrl
// ----------------------------------------------------------------------------
// Credit-based dispatch controller for the RVV backend. Each reservation
// station class (alu, pmtrdt, mul, div, lsu) and the ROB are tracked by a
// registered free-entry counter. Every cycle the longest in-order prefix of up
// to NUM_DP uops that fits the remaining credits is dispatched. Several slots
// may target the same class in one cycle.
//
// Execution unit encoding on uop_exe_unit (4 bits per slot):
//   0 ALU, 1 MUL, 2 PMT, 3 DIV, 4 CMP, 5 RDT, 6 MAC, 7 LSU, 8..15 unmapped.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   uop_valid_uop2dp          slot valid from the UOP queue
//   uop_exe_unit              target execution unit per slot
//   uop_last                  last uop of the instruction
//   uop_hazard                slot must not issue this cycle
//   flush                     suppress all dispatch this cycle
//   uop_ready_dp2uop          slot popped from the UOP queue
//   rs_valid_dp2<class>       RS push strobes per class
//   mapinfo_valid_dp2lsu      same as rs_valid_dp2lsu
//   uop_valid_dp2rob          ROB allocation strobe
//   <class>_ret, rob_ret      entries freed this cycle (seen next cycle)
//   credit_err                sticky return-overflow flag, cleared by rst
//
// Optional feature macro RVV_DP_STALL_CNT_EN adds:
//   stall_cnt   [31:0]        cycles the head uop was dispatchable but held
//   stall_cause [2:0]         registered cause of first blocked slot
//                             (1 RS credit, 2 ROB, 0 none)
// ----------------------------------------------------------------------------
module rvv_backend_dispatch_credit_ctrl #(
  parameter int NUM_DP       = 2,
  parameter int ALU_DEPTH    = 8,
  parameter int PMTRDT_DEPTH = 8,
  parameter int MUL_DEPTH    = 8,
  parameter int DIV_DEPTH    = 4,
  parameter int LSU_DEPTH    = 8,
  parameter int ROB_DEPTH    = 8,
  parameter int CW           = $clog2(NUM_DP+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DP-1:0]      uop_valid_uop2dp,
  input  logic [NUM_DP-1:0][3:0] uop_exe_unit,
  input  logic [NUM_DP-1:0]      uop_last,
  input  logic [NUM_DP-1:0]      uop_hazard,
  input  logic                   flush,
  output logic [NUM_DP-1:0]      uop_ready_dp2uop,
  output logic [NUM_DP-1:0]      rs_valid_dp2alu,
  output logic [NUM_DP-1:0]      rs_valid_dp2pmtrdt,
  output logic [NUM_DP-1:0]      rs_valid_dp2mul,
  output logic [NUM_DP-1:0]      rs_valid_dp2div,
  output logic [NUM_DP-1:0]      rs_valid_dp2lsu,
  output logic [NUM_DP-1:0]      mapinfo_valid_dp2lsu,
  output logic [NUM_DP-1:0]      uop_valid_dp2rob,
  input  logic [CW-1:0]          alu_ret,
  input  logic [CW-1:0]          pmtrdt_ret,
  input  logic [CW-1:0]          mul_ret,
  input  logic [CW-1:0]          div_ret,
  input  logic [CW-1:0]          lsu_ret,
  input  logic [CW-1:0]          rob_ret,
`ifdef RVV_DP_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
  output logic [2:0]             stall_cause,
`endif
  output logic                   credit_err
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter width covers every class and the ROB.
  localparam int MAXD = imax(imax(imax(ALU_DEPTH, PMTRDT_DEPTH), imax(MUL_DEPTH, DIV_DEPTH)),
                             imax(LSU_DEPTH, ROB_DEPTH));
  localparam int CNTW = imax($clog2(MAXD+1), CW);
  localparam int CW1  = CNTW + 1;
  localparam int SW   = CNTW + CW + 1;
  localparam int NCLS = 5;

  localparam logic [3:0] UNIT_ALU = 4'd0;
  localparam logic [3:0] UNIT_MUL = 4'd1;
  localparam logic [3:0] UNIT_PMT = 4'd2;
  localparam logic [3:0] UNIT_DIV = 4'd3;
  localparam logic [3:0] UNIT_CMP = 4'd4;
  localparam logic [3:0] UNIT_RDT = 4'd5;
  localparam logic [3:0] UNIT_MAC = 4'd6;
  localparam logic [3:0] UNIT_LSU = 4'd7;

  localparam logic [2:0] CLS_ALU  = 3'd0;
  localparam logic [2:0] CLS_PMT  = 3'd1;
  localparam logic [2:0] CLS_MUL  = 3'd2;
  localparam logic [2:0] CLS_DIV  = 3'd3;
  localparam logic [2:0] CLS_LSU  = 3'd4;
  localparam logic [2:0] CLS_NONE = 3'd5;

  localparam logic [CNTW-1:0] CLS_DEPTH [NCLS] = '{CNTW'(ALU_DEPTH), CNTW'(PMTRDT_DEPTH),
                                                   CNTW'(MUL_DEPTH), CNTW'(DIV_DEPTH),
                                                   CNTW'(LSU_DEPTH)};

  function automatic logic [2:0] class_of(input logic [3:0] unit);
    case (unit)
      UNIT_ALU:                     return CLS_ALU;
      UNIT_PMT, UNIT_RDT, UNIT_CMP: return CLS_PMT;
      UNIT_MUL, UNIT_MAC:           return CLS_MUL;
      UNIT_DIV:                     return CLS_DIV;
      UNIT_LSU:                     return CLS_LSU;
      default:                      return CLS_NONE;
    endcase
  endfunction

  // Non-final CMP/RDT uops share the ROB entry of the last uop.
  function automatic logic rob_need(input logic [3:0] unit, input logic last);
    return ~(((unit == UNIT_CMP) || (unit == UNIT_RDT)) && !last);
  endfunction

  // Returns {overflow, next}; overflow saturates the counter at depth.
  function automatic logic [CNTW:0] credit_update(input logic [CNTW-1:0] cur,
                                                  input logic [CNTW-1:0] used,
                                                  input logic [CW-1:0]   ret,
                                                  input logic [CNTW-1:0] depth);
    logic [SW-1:0] sum;
    sum = SW'(cur) + SW'(ret) - SW'(used);
    if ((sum > SW'(depth)) || ((ret != '0) && (cur == depth))) begin
      return {1'b1, depth};
    end else begin
      return {1'b0, sum[CNTW-1:0]};
    end
  endfunction

  logic [CNTW-1:0]   cred_r [NCLS];
  logic [CNTW-1:0]   rob_free_r;
  logic [CNTW-1:0]   cred_nxt_s [NCLS];
  logic [CNTW-1:0]   rob_nxt_s;
  logic [CNTW-1:0]   cnt_s [NCLS];
  logic [CNTW-1:0]   rob_cnt_s;
  logic [CW-1:0]     ret_s [NCLS];
  logic [CNTW:0]     upd_s;
  logic              ovf_s;
  logic [2:0]        cls_s [NUM_DP];
  logic [NUM_DP-1:0] need_s;
  logic [NUM_DP-1:0] issue_s;
  logic              chain_s;
  logic              cred_ok_s;
  logic              rob_ok_s;
`ifdef RVV_DP_STALL_CNT_EN
  logic [2:0]        cause_s;
  logic              head_stall_s;
`endif

  // In-order prefix selection against cumulative per-class and ROB usage.
  always_comb begin
    chain_s   = ~rst & ~flush;
    rob_cnt_s = '0;
    issue_s   = '0;
    cred_ok_s = 1'b0;
    rob_ok_s  = 1'b0;
`ifdef RVV_DP_STALL_CNT_EN
    cause_s   = 3'd0;
`endif
    for (int c = 0; c < NCLS; c++) begin
      cnt_s[c] = '0;
    end
    for (int i = 0; i < NUM_DP; i++) begin
      cls_s[i]  = class_of(uop_exe_unit[i]);
      need_s[i] = rob_need(uop_exe_unit[i], uop_last[i]);
    end
    for (int i = 0; i < NUM_DP; i++) begin
      cred_ok_s = 1'b0;
      for (int c = 0; c < NCLS; c++) begin
        cred_ok_s = cred_ok_s | ((cls_s[i] == 3'(c)) &
                    (({1'b0, cnt_s[c]} + CW1'(1)) <= {1'b0, cred_r[c]}));
      end
      rob_ok_s   = ({1'b0, rob_cnt_s} + CW1'(need_s[i])) <= {1'b0, rob_free_r};
      issue_s[i] = chain_s & uop_valid_uop2dp[i] & ~uop_hazard[i] &
                   (cls_s[i] != CLS_NONE) & cred_ok_s & rob_ok_s;
`ifdef RVV_DP_STALL_CNT_EN
      // Only the first slot that breaks the chain records a cause.
      cause_s = (chain_s & ~issue_s[i]) ?
                ((uop_valid_uop2dp[i] & ~uop_hazard[i] & (cls_s[i] != CLS_NONE)) ?
                 (~cred_ok_s ? 3'd1 : (~rob_ok_s ? 3'd2 : 3'd0)) : 3'd0) : cause_s;
`endif
      for (int c = 0; c < NCLS; c++) begin
        cnt_s[c] = cnt_s[c] + CNTW'(issue_s[i] & (cls_s[i] == 3'(c)));
      end
      rob_cnt_s = rob_cnt_s + CNTW'(issue_s[i] & need_s[i]);
      chain_s   = issue_s[i];
    end
  end

  // Decode issued slots into per-class strobes.
  always_comb begin
    uop_ready_dp2uop = issue_s;
    for (int i = 0; i < NUM_DP; i++) begin
      rs_valid_dp2alu[i]      = issue_s[i] & (cls_s[i] == CLS_ALU);
      rs_valid_dp2pmtrdt[i]   = issue_s[i] & (cls_s[i] == CLS_PMT);
      rs_valid_dp2mul[i]      = issue_s[i] & (cls_s[i] == CLS_MUL);
      rs_valid_dp2div[i]      = issue_s[i] & (cls_s[i] == CLS_DIV);
      rs_valid_dp2lsu[i]      = issue_s[i] & (cls_s[i] == CLS_LSU);
      mapinfo_valid_dp2lsu[i] = issue_s[i] & (cls_s[i] == CLS_LSU);
      uop_valid_dp2rob[i]     = issue_s[i] & need_s[i];
    end
  end

  // Next credit values: subtract this cycle's dispatch, add returns.
  always_comb begin
    ret_s[0] = alu_ret;
    ret_s[1] = pmtrdt_ret;
    ret_s[2] = mul_ret;
    ret_s[3] = div_ret;
    ret_s[4] = lsu_ret;
    ovf_s    = 1'b0;
    for (int c = 0; c < NCLS; c++) begin
      upd_s         = credit_update(cred_r[c], cnt_s[c], ret_s[c], CLS_DEPTH[c]);
      cred_nxt_s[c] = upd_s[CNTW-1:0];
      ovf_s         = ovf_s | upd_s[CNTW];
    end
    upd_s     = credit_update(rob_free_r, rob_cnt_s, rob_ret, CNTW'(ROB_DEPTH));
    rob_nxt_s = upd_s[CNTW-1:0];
    ovf_s     = ovf_s | upd_s[CNTW];
  end

  // Credit counters and sticky overflow flag; returns during rst are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCLS; c++) begin
        cred_r[c] <= CLS_DEPTH[c];
      end
      rob_free_r <= CNTW'(ROB_DEPTH);
      credit_err <= 1'b0;
    end else begin
      for (int c = 0; c < NCLS; c++) begin
        cred_r[c] <= cred_nxt_s[c];
      end
      rob_free_r <= rob_nxt_s;
      credit_err <= credit_err | ovf_s;
    end
  end

`ifdef RVV_DP_STALL_CNT_EN
  assign head_stall_s = uop_valid_uop2dp[0] & ~uop_hazard[0] & ~flush & ~issue_s[0];

  // Stall statistics: wrapping count of held head cycles and last cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= 32'd0;
      stall_cause <= 3'd0;
    end else begin
      if (head_stall_s) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      stall_cause <= cause_s;
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_dispatch_credit_ctrl.sv
// Self-checking bench for rvv_backend_dispatch_credit_ctrl (default params).
// Each stimulus cycle pushes its hand-derived expected strobes and credit_err
// into a scoreboard queue; a negedge sampler pops and compares.
module tb_rvv_backend_dispatch_credit_ctrl;
  localparam int NUM_DP = 2;
  localparam int CW     = 2;

  localparam logic [3:0] ALU = 4'd0;
  localparam logic [3:0] MUL = 4'd1;
  localparam logic [3:0] PMT = 4'd2;
  localparam logic [3:0] DIV = 4'd3;
  localparam logic [3:0] CMP = 4'd4;
  localparam logic [3:0] RDT = 4'd5;
  localparam logic [3:0] MAC = 4'd6;
  localparam logic [3:0] LSU = 4'd7;
  localparam logic [3:0] BAD = 4'd15;
  localparam logic [15:0] Z  = 16'h0000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_DP-1:0]      uop_valid_uop2dp = '0;
  logic [NUM_DP-1:0][3:0] uop_exe_unit = '0;
  logic [NUM_DP-1:0]      uop_last = '0;
  logic [NUM_DP-1:0]      uop_hazard = '0;
  logic                   flush = 1'b0;
  logic [NUM_DP-1:0]      uop_ready_dp2uop, rs_valid_dp2alu, rs_valid_dp2pmtrdt;
  logic [NUM_DP-1:0]      rs_valid_dp2mul, rs_valid_dp2div, rs_valid_dp2lsu;
  logic [NUM_DP-1:0]      mapinfo_valid_dp2lsu, uop_valid_dp2rob;
  logic [CW-1:0]          alu_ret = '0, pmtrdt_ret = '0, mul_ret = '0;
  logic [CW-1:0]          div_ret = '0, lsu_ret = '0, rob_ret = '0;
  logic                   credit_err;
`ifdef RVV_DP_STALL_CNT_EN
  logic [31:0]            stall_cnt;
  logic [2:0]             stall_cause;
`endif

  always #5 clk = ~clk;

  rvv_backend_dispatch_credit_ctrl dut (
    .clk(clk), .rst(rst),
    .uop_valid_uop2dp(uop_valid_uop2dp), .uop_exe_unit(uop_exe_unit),
    .uop_last(uop_last), .uop_hazard(uop_hazard), .flush(flush),
    .uop_ready_dp2uop(uop_ready_dp2uop),
    .rs_valid_dp2alu(rs_valid_dp2alu), .rs_valid_dp2pmtrdt(rs_valid_dp2pmtrdt),
    .rs_valid_dp2mul(rs_valid_dp2mul), .rs_valid_dp2div(rs_valid_dp2div),
    .rs_valid_dp2lsu(rs_valid_dp2lsu), .mapinfo_valid_dp2lsu(mapinfo_valid_dp2lsu),
    .uop_valid_dp2rob(uop_valid_dp2rob),
    .alu_ret(alu_ret), .pmtrdt_ret(pmtrdt_ret), .mul_ret(mul_ret),
    .div_ret(div_ret), .lsu_ret(lsu_ret), .rob_ret(rob_ret),
`ifdef RVV_DP_STALL_CNT_EN
    .stall_cnt(stall_cnt), .stall_cause(stall_cause),
`endif
    .credit_err(credit_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] strobes;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  // Strobe vector layout: {ready, alu, pmtrdt, mul, div, lsu, mapinfo, rob}.
  function automatic logic [15:0] pk(input logic [1:0] rdy, input logic [1:0] alu,
                                     input logic [1:0] pmt, input logic [1:0] mul,
                                     input logic [1:0] div, input logic [1:0] lsu,
                                     input logic [1:0] rob);
    return {rdy, alu, pmt, mul, div, lsu, lsu, rob};
  endfunction

  logic [15:0] obs;
  assign obs = {uop_ready_dp2uop, rs_valid_dp2alu, rs_valid_dp2pmtrdt, rs_valid_dp2mul,
                rs_valid_dp2div, rs_valid_dp2lsu, mapinfo_valid_dp2lsu, uop_valid_dp2rob};

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("c%0d strobes", e.cyc), {16'h0, obs}, {16'h0, e.strobes});
      check($sformatf("c%0d credit_err", e.cyc), {31'h0, credit_err}, {31'h0, e.err});
    end
  end

  // Slot fields are given as {slot1, slot0}; clears returns, flush and rst.
  task automatic set_in(input logic [1:0] v, input logic [3:0] u1, input logic [3:0] u0,
                        input logic [1:0] last, input logic [1:0] hz);
    uop_valid_uop2dp = v;
    uop_exe_unit     = {u1, u0};
    uop_last         = last;
    uop_hazard       = hz;
    flush = 1'b0; rst = 1'b0;
    alu_ret = '0; pmtrdt_ret = '0; mul_ret = '0; div_ret = '0; lsu_ret = '0; rob_ret = '0;
  endtask

  task automatic step(input logic [15:0] s, input logic e);
    exp_t x;
    x.strobes = s; x.err = e; x.cyc = cyc;
    sb_q.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset: strobes held low despite valid uops; returns ignored.
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00); rst = 1'b1; step(Z, 1'b0);
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00); rst = 1'b1; alu_ret = 2'd1; step(Z, 1'b0);

    // ALU credits 8 -> 0 in four cycles; ROB refilled lagging by one cycle.
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, ALU, ALU, 2'b11, 2'b00);
      rob_ret = (k > 0) ? 2'd2 : 2'd0;
      step(pk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11), 1'b0);
    end
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd1; rob_ret = 2'd2; step(Z, 1'b0);
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00);
    step(pk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01), 1'b0);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd2; rob_ret = 2'd1; step(Z, 1'b0);

    // DIV drained to 0, then MUL+DIV: only MUL goes; head hazard blocks both.
    for (int k = 0; k < 2; k++) begin
      set_in(2'b11, DIV, DIV, 2'b11, 2'b00);
      step(pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11), 1'b0);
    end
    set_in(2'b11, DIV, MUL, 2'b11, 2'b00);
    step(pk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01), 1'b0);
    set_in(2'b11, DIV, MUL, 2'b11, 2'b01); div_ret = 2'd2; mul_ret = 2'd1; rob_ret = 2'd3;
    step(Z, 1'b0);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); div_ret = 2'd2; alu_ret = 2'd3; rob_ret = 2'd2;
    step(Z, 1'b0);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd3; step(Z, 1'b0);

    // Bring ROB to 1 free, then CMP chain: only the last CMP allocates ROB.
    for (int k = 0; k < 3; k++) begin
      set_in(2'b11, ALU, ALU, 2'b11, 2'b00);
      step(pk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11), 1'b0);
    end
    set_in(2'b01, ALU, ALU, 2'b11, 2'b00);
    step(pk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01), 1'b0);
    set_in(2'b11, CMP, CMP, 2'b00, 2'b00);
    step(pk(2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
    set_in(2'b11, ALU, CMP, 2'b01, 2'b00);
    step(pk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01), 1'b0);
    // ROB now 0: a non-final RDT still issues, ALU behind it does not.
    set_in(2'b11, ALU, RDT, 2'b00, 2'b00);
    step(pk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd3; pmtrdt_ret = 2'd3; rob_ret = 2'd3;
    step(Z, 1'b0);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd3; pmtrdt_ret = 2'd1; rob_ret = 2'd3;
    step(Z, 1'b0);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd1; rob_ret = 2'd2; step(Z, 1'b0);

    // LSU drained to 1; dispatch one with a same-cycle return keeps it at 1.
    for (int k = 0; k < 3; k++) begin
      set_in(2'b11, LSU, LSU, 2'b11, 2'b00);
      step(pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11), 1'b0);
    end
    set_in(2'b01, LSU, LSU, 2'b11, 2'b00);
    step(pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01), 1'b0);
    set_in(2'b11, LSU, LSU, 2'b11, 2'b00); lsu_ret = 2'd1;
    step(pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01), 1'b0);
    set_in(2'b00, LSU, LSU, 2'b11, 2'b00); rob_ret = 2'd3; step(Z, 1'b0);
    set_in(2'b11, LSU, LSU, 2'b11, 2'b00); lsu_ret = 2'd3; rob_ret = 2'd3;
    step(pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01), 1'b0);
    set_in(2'b00, LSU, LSU, 2'b11, 2'b00); lsu_ret = 2'd3; rob_ret = 2'd3; step(Z, 1'b0);
    set_in(2'b00, LSU, LSU, 2'b11, 2'b00); lsu_ret = 2'd2; step(Z, 1'b0);

    // Return into a full counter: sticky error, counter stays at depth.
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); alu_ret = 2'd1; step(Z, 1'b0);
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00); flush = 1'b1; step(Z, 1'b1);
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00);
    step(pk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11), 1'b1);
    set_in(2'b11, ALU, BAD, 2'b11, 2'b00); step(Z, 1'b1);
    set_in(2'b11, PMT, MAC, 2'b11, 2'b00);
    step(pk(2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11), 1'b1);

    // Mid-run reset clears the error and reloads DIV to 4.
    set_in(2'b11, ALU, ALU, 2'b11, 2'b00); rst = 1'b1; step(Z, 1'b1);
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); step(Z, 1'b0);
    for (int k = 0; k < 2; k++) begin
      set_in(2'b11, DIV, DIV, 2'b11, 2'b00);
      step(pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11), 1'b0);
    end
    set_in(2'b11, DIV, DIV, 2'b11, 2'b00); step(Z, 1'b0);

`ifdef RVV_DP_STALL_CNT_EN
    // Fill the ROB, then hold a valid head uop for five cycles.
    set_in(2'b00, ALU, ALU, 2'b11, 2'b00); rst = 1'b1; step(Z, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, LSU, ALU, 2'b11, 2'b00);
      step(pk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11), 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      set_in(2'b01, ALU, ALU, 2'b11, 2'b00); step(Z, 1'b0);
    end
    check("stall_cnt", stall_cnt, 32'd5);
    check("stall_cause", {29'h0, stall_cause}, 32'd2);
`endif

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
